// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency/period meter: default gate length,
// period FSM state encoding and a constant-width helper.
package freq_meter_pkg;

  localparam int unsigned DEFAULT_GATE_CYCLES = 1000000;

  typedef enum logic {
    WAIT_FIRST = 1'b0,
    MEASURE    = 1'b1
  } per_state_t;

  // Ceiling log2, used to size counters from their terminal count.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned v;
    int unsigned r;
    v = value - 1;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((v >> i) != 0) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/freq_meter_sync_edge_det.sv
// Two-flop synchroniser followed by an edge register; emits a one-cycle pulse
// for each rising edge of an input that is asynchronous to clk.
module freq_meter_sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  // Synchroniser chain plus the delayed copy used for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/freq_meter.sv
// Frequency and period meter: counts synchronised rising edges of sig_in over a
// fixed gate window, and measures clk cycles between consecutive rising edges.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int unsigned GATE_CYCLES = DEFAULT_GATE_CYCLES,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned PER_W       = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq_count,
  output logic             freq_valid,
  output logic             freq_ovf,
  output logic [PER_W-1:0] period,
  output logic             period_valid,
  output logic             period_timeout
);

  localparam int unsigned       GATE_W    = clog2(GATE_CYCLES);
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic [PER_W-1:0]  PER_MAX   = '1;
  localparam logic [PER_W-1:0]  PER_ONE   = PER_W'(1);

  logic              edge_p;
  logic              run;
  logic              active;
  logic [GATE_W-1:0] gate_cnt;
  logic [CNT_W-1:0]  edge_cnt;
  logic              edge_sat;
  logic [CNT_W-1:0]  cnt_next;
  logic              lost_edge;
  logic [PER_W-1:0]  per_cnt;
  per_state_t        state;

  freq_meter_sync_edge_det u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (sig_in),
    .rise     (edge_p)
  );

  // Enable is registered so a new window always starts on a whole cycle after
  // en is first sampled high; dropping en still stops counting immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) run <= 1'b0;
    else     run <= en;
  end

  assign active = en & run;

  // Saturating edge-count increment; flags an edge that could not be counted.
  always_comb begin
    cnt_next  = edge_cnt;
    lost_edge = 1'b0;
    if (edge_p) begin
      if (edge_cnt == CNT_MAX) lost_edge = 1'b1;
      else                     cnt_next  = edge_cnt + 1'b1;
    end
  end

  // Gate window: count edges, publish the total on the terminal cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      edge_sat   <= 1'b0;
      freq_count <= '0;
      freq_valid <= 1'b0;
      freq_ovf   <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      if (!active) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        edge_sat <= 1'b0;
      end else if (gate_cnt == GATE_LAST) begin
        // An edge on the terminal cycle belongs to the window being closed.
        gate_cnt   <= '0;
        freq_count <= cnt_next;
        freq_ovf   <= edge_sat | lost_edge;
        freq_valid <= 1'b1;
        edge_cnt   <= '0;
        edge_sat   <= 1'b0;
      end else begin
        gate_cnt <= gate_cnt + 1'b1;
        edge_cnt <= cnt_next;
        edge_sat <= edge_sat | lost_edge;
      end
    end
  end

  // Period FSM: time between consecutive edges, with timeout on a silent input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= WAIT_FIRST;
      per_cnt        <= '0;
      period         <= '0;
      period_valid   <= 1'b0;
      period_timeout <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (!active) begin
        state   <= WAIT_FIRST;
        per_cnt <= '0;
      end else begin
        case (state)
          WAIT_FIRST: begin
            if (edge_p) begin
              state   <= MEASURE;
              per_cnt <= PER_ONE;
            end
          end
          MEASURE: begin
            // An edge arriving on the timeout cycle takes priority.
            if (edge_p) begin
              period         <= per_cnt;
              period_valid   <= 1'b1;
              period_timeout <= 1'b0;
              per_cnt        <= PER_ONE;
            end else if (per_cnt == PER_MAX) begin
              period_timeout <= 1'b1;
              per_cnt        <= '0;
              state          <= WAIT_FIRST;
            end else begin
              per_cnt <= per_cnt + 1'b1;
            end
          end
          default: begin
            state   <= WAIT_FIRST;
            per_cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule
